// File: rtl/dac_wave_seq.sv
// Waveform sequencer for the DAC / ring-oscillator test macro: generates a DAC code
// in static/saw/triangle/square mode and measures ring-oscillator edges per gate window.
module dac_wave_seq #(
    parameter int DAC_BITS  = 3,
    parameter int DIV_BITS  = 8,
    parameter int GATE_BITS = 8,
    parameter int CNT_BITS  = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 cfg_load,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_BITS-1:0]  cfg_div,
    input  logic [DAC_BITS-1:0]  cfg_amp,
    input  logic                 ro_in,
    output logic [DAC_BITS-1:0]  dac_code,
    output logic                 dac_en,
    output logic                 wrap,
    output logic [CNT_BITS-1:0]  ro_count,
    output logic                 ro_valid
);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_SQUARE = 2'b11
    } mode_t;

    localparam logic [DAC_BITS-1:0]  CODE_ONE = DAC_BITS'(1);
    localparam logic [DAC_BITS-1:0]  CODE_MAX = {DAC_BITS{1'b1}};
    localparam logic [DAC_BITS-1:0]  CODE_TOP = CODE_MAX - CODE_ONE;
    localparam logic [DIV_BITS-1:0]  DIV_ONE  = DIV_BITS'(1);
    localparam logic [GATE_BITS-1:0] GATE_ONE = GATE_BITS'(1);
    localparam logic [GATE_BITS-1:0] GATE_MAX = {GATE_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = {CNT_BITS{1'b1}};

    mode_t               mode;
    logic [DIV_BITS-1:0] div;
    logic [DAC_BITS-1:0] amp;
    logic [DIV_BITS-1:0] presc;
    // Triangle: count direction. Square: set while the next step goes to amp.
    logic                dir_up;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= MODE_STATIC;
            div      <= '0;
            amp      <= '0;
            presc    <= '0;
            dir_up   <= 1'b1;
            dac_code <= '0;
            dac_en   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            dac_en <= ena;
            wrap   <= 1'b0;
            if (cfg_load) begin
                mode     <= mode_t'(cfg_mode);
                div      <= cfg_div;
                amp      <= cfg_amp;
                presc    <= '0;
                dir_up   <= 1'b1;
                dac_code <= (mode_t'(cfg_mode) == MODE_STATIC) ? cfg_amp : '0;
            end else if (ena) begin
                if (presc != div) begin
                    presc <= presc + DIV_ONE;
                end else begin
                    presc <= '0;
                    unique case (mode)
                        MODE_STATIC: dac_code <= amp;
                        MODE_SAW: begin
                            dac_code <= dac_code + CODE_ONE;
                            wrap     <= (dac_code == CODE_MAX);
                        end
                        MODE_TRI: begin
                            if (dir_up) begin
                                dac_code <= dac_code + CODE_ONE;
                                if (dac_code == CODE_TOP) dir_up <= 1'b0;
                            end else begin
                                dac_code <= dac_code - CODE_ONE;
                                if (dac_code == CODE_ONE) begin
                                    dir_up <= 1'b1;
                                    wrap   <= 1'b1;
                                end
                            end
                        end
                        MODE_SQUARE: begin
                            // Phase bit, not the code, drives the toggle so amp=0 still wraps.
                            if (dir_up) begin
                                dac_code <= amp;
                                dir_up   <= 1'b0;
                            end else begin
                                dac_code <= '0;
                                dir_up   <= 1'b1;
                                wrap     <= 1'b1;
                            end
                        end
                        default: dac_code <= dac_code;
                    endcase
                end
            end
        end
    end

    logic                 ro_meta, ro_sync, ro_prev;
    logic                 ro_edge;
    logic [GATE_BITS-1:0] gate_cnt;
    logic [CNT_BITS-1:0]  edge_cnt;
    logic [CNT_BITS-1:0]  edge_next;

    assign ro_edge = ro_sync & ~ro_prev;

    always_comb begin
        edge_next = edge_cnt;
        if (ro_edge && (edge_cnt != CNT_MAX)) edge_next = edge_cnt + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ro_meta  <= 1'b0;
            ro_sync  <= 1'b0;
            ro_prev  <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ro_count <= '0;
            ro_valid <= 1'b0;
        end else begin
            ro_meta <= ro_in;
            ro_sync <= ro_meta;
            ro_prev <= ro_sync;
            if (!ena) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
                ro_valid <= 1'b0;
            end else begin
                gate_cnt <= gate_cnt + GATE_ONE;
                ro_valid <= (gate_cnt == GATE_MAX);
                if (gate_cnt == GATE_MAX) begin
                    ro_count <= edge_next;
                    edge_cnt <= '0;
                end else begin
                    edge_cnt <= edge_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_wave_seq.sv
// Scoreboard bench for dac_wave_seq: stimulus queues expected DAC steps and edge
// counts; monitors pop and compare whenever the DUTs present an output.
module tb_dac_wave_seq;

    typedef struct {
        logic [2:0] code;
        logic       wrap;
        logic       en;
    } dac_exp_t;

    typedef struct {
        int lo;
        int hi;
    } ro_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        cfg_load;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_div;
    logic [2:0]  cfg_amp;
    logic        ro_in = 1'b0;
    logic [2:0]  dac_code;
    logic        dac_en;
    logic        wrap;
    logic [11:0] ro_count;
    logic        ro_valid;
    logic [2:0]  dac_code2;
    logic        dac_en2;
    logic        wrap2;
    logic [5:0]  ro_count2;
    logic        ro_valid2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ro_half = 0;
    int ro_ph = 0;
    int last_t1 = -1;
    int last_t2 = -1;
    bit ro_mon_on = 1'b0;

    dac_exp_t dq[$];
    ro_exp_t  rq1[$];
    ro_exp_t  rq2[$];
    logic [2:0] tri_exp [16];

    dac_wave_seq dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
        .cfg_div(cfg_div), .cfg_amp(cfg_amp), .ro_in(ro_in), .dac_code(dac_code),
        .dac_en(dac_en), .wrap(wrap), .ro_count(ro_count), .ro_valid(ro_valid)
    );

    dac_wave_seq #(.CNT_BITS(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
        .cfg_div(cfg_div), .cfg_amp(cfg_amp), .ro_in(ro_in), .dac_code(dac_code2),
        .dac_en(dac_en2), .wrap(wrap2), .ro_count(ro_count2), .ro_valid(ro_valid2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d at t=%0t", name, act, lo, hi, $time);
        end
    endtask

    // Called at a negedge with inputs already set; describes the outputs after the next posedge.
    task automatic expect_cyc(input logic [2:0] c, input logic w, input logic e);
        dac_exp_t x;
        x.code = c;
        x.wrap = w;
        x.en   = e;
        dq.push_back(x);
        @(negedge clk);
    endtask

    task automatic push_ro(input int lo1, input int hi1, input int lo2, input int hi2);
        ro_exp_t r;
        r.lo = lo1; r.hi = hi1;
        rq1.push_back(r);
        r.lo = lo2; r.hi = hi2;
        rq2.push_back(r);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (ro_half > 0) begin
            ro_ph++;
            if (ro_ph >= ro_half) begin
                ro_ph = 0;
                ro_in = ~ro_in;
            end
        end
    end

    initial begin
        dac_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dq.size() > 0) begin
                e = dq.pop_front();
                check("dac_code", int'(dac_code), int'(e.code), int'(e.code));
                check("wrap", int'(wrap), int'(e.wrap), int'(e.wrap));
                check("dac_en", int'(dac_en), int'(e.en), int'(e.en));
            end
        end
    end

    initial begin
        ro_exp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!ena) last_t1 = -1;
            if (ro_mon_on && ro_valid) begin
                if (rq1.size() == 0) begin
                    check("ro_valid_unexpected", 1, 0, 0);
                end else begin
                    r = rq1.pop_front();
                    check("ro_count", int'(ro_count), r.lo, r.hi);
                end
                if (last_t1 >= 0) check("ro_interval", cyc - last_t1, 256, 256);
                last_t1 = cyc;
            end
        end
    end

    initial begin
        ro_exp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (!ena) last_t2 = -1;
            if (ro_mon_on && ro_valid2) begin
                if (rq2.size() == 0) begin
                    check("ro_valid_unexpected_sat", 1, 0, 0);
                end else begin
                    r = rq2.pop_front();
                    check("ro_count_sat", int'(ro_count2), r.lo, r.hi);
                end
                if (last_t2 >= 0) check("ro_interval_sat", cyc - last_t2, 256, 256);
                last_t2 = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tri_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
                    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2};
        rst_n = 1'b0; ena = 1'b0; cfg_load = 1'b0;
        cfg_mode = 2'b00; cfg_div = 8'd0; cfg_amp = 3'd0;

        #3;
        check("rst_dac_code", int'(dac_code), 0, 0);
        check("rst_dac_en", int'(dac_en), 0, 0);
        check("rst_wrap", int'(wrap), 0, 0);
        check("rst_ro_count", int'(ro_count), 0, 0);
        check("rst_ro_valid", int'(ro_valid), 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Ring oscillator with a 10-cycle period: 25 or 26 rising edges per 256-cycle window.
        ro_mon_on = 1'b1;
        ro_half = 5;
        push_ro(25, 26, 25, 26);
        push_ro(25, 26, 25, 26);
        ena = 1'b1;
        repeat (520) @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        check("ro_hold_after_ena_low", int'(ro_count), 25, 26);
        check("ro_valid_low_when_idle", int'(ro_valid), 0, 0);
        check("ro_drain_1", rq1.size(), 0, 0);
        check("ro_drain_sat_1", rq2.size(), 0, 0);

        // Toggle every clk: ~128 edges per window, which the 6-bit counter clips at 63.
        ro_half = 1;
        push_ro(127, 128, 63, 63);
        push_ro(127, 128, 63, 63);
        ena = 1'b1;
        repeat (520) @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        check("ro_drain_2", rq1.size(), 0, 0);
        check("ro_drain_sat_2", rq2.size(), 0, 0);
        ro_mon_on = 1'b0;
        ro_half = 5;

        // Saw, div=2: one step per 3 cycles, wrap on the 7->0 step.
        cfg_load = 1'b1; cfg_mode = 2'b01; cfg_div = 8'd2; cfg_amp = 3'd0; ena = 1'b1;
        expect_cyc(3'd0, 1'b0, 1'b1);
        cfg_load = 1'b0;
        for (int k = 1; k <= 50; k++)
            expect_cyc(3'((k / 3) % 8), (k % 3 == 0) && ((k / 3) % 8 == 0), 1'b1);

        // Triangle, div=0: 0..7..0 with a 14-step period.
        cfg_load = 1'b1; cfg_mode = 2'b10; cfg_div = 8'd0;
        expect_cyc(3'd0, 1'b0, 1'b1);
        cfg_load = 1'b0;
        for (int i = 0; i < 16; i++)
            expect_cyc(tri_exp[i], tri_exp[i] == 3'd0, 1'b1);

        // Square, amp=5, div=1, then a 5-cycle freeze.
        cfg_load = 1'b1; cfg_mode = 2'b11; cfg_div = 8'd1; cfg_amp = 3'd5;
        expect_cyc(3'd0, 1'b0, 1'b1);
        cfg_load = 1'b0;
        for (int k = 1; k <= 6; k++)
            expect_cyc(((k / 2) % 2 == 1) ? 3'd5 : 3'd0, (k % 2 == 0) && ((k / 2) % 2 == 0), 1'b1);
        ena = 1'b0;
        repeat (5) expect_cyc(3'd5, 1'b0, 1'b0);
        ena = 1'b1;
        expect_cyc(3'd5, 1'b0, 1'b1);
        expect_cyc(3'd0, 1'b1, 1'b1);
        expect_cyc(3'd0, 1'b0, 1'b1);
        expect_cyc(3'd5, 1'b0, 1'b1);
        expect_cyc(3'd5, 1'b0, 1'b1);

        // A square tick (5->0 with wrap) is due on this edge; the load must win.
        cfg_load = 1'b1; cfg_mode = 2'b00; cfg_amp = 3'd3;
        expect_cyc(3'd3, 1'b0, 1'b1);
        cfg_load = 1'b0;
        repeat (4) expect_cyc(3'd3, 1'b0, 1'b1);

        // Reload to saw mid-sequence: code restarts at 0.
        cfg_load = 1'b1; cfg_mode = 2'b01; cfg_div = 8'd0;
        expect_cyc(3'd0, 1'b0, 1'b1);
        cfg_load = 1'b0;
        for (int k = 1; k <= 5; k++) expect_cyc(3'(k), 1'b0, 1'b1);

        // Asynchronous reset between edges at code=5.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dac_code", int'(dac_code), 0, 0);
        check("async_rst_dac_en", int'(dac_en), 0, 0);
        check("async_rst_wrap", int'(wrap), 0, 0);
        check("async_rst_ro_count", int'(ro_count), 0, 0);
        check("async_rst_ro_valid", int'(ro_valid), 0, 0);
        check("async_rst_ro_count_sat", int'(ro_count2), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // Back in static mode with amp=0: code stays 0 even though cfg_mode still reads saw.
        repeat (4) expect_cyc(3'd0, 1'b0, 1'b1);

        ena = 1'b0;
        repeat (2) @(negedge clk);
        check("dac_queue_drained", dq.size(), 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
